// File: rtl/c7b_rd_arb.sv
// c7b_rd_arb: read-channel arbiter/sequencer between three read requesters
// (LSU, IFU uncached fetch, ICU line refill) and one AXI-style AR/R pair.
// One read transaction outstanding at a time; returning R beats are steered
// to the owner of the current grant with zero-cycle pass-through.
//
// Optional build macro: C7B_RD_ARB_RR_EN
//   defined   -> round-robin arbitration (LSU -> ICU -> IFU -> LSU rotation,
//                2-bit last-grant register updated on the AR handshake)
//   undefined -> fixed priority LSU > ICU > IFU
//
// Ports:
//   clk, resetn                       clock, async active-low reset
//   lsu_rd_req/addr/ack/data_valid    LSU read requester
//   ifu_rd_req/addr/ack/data_valid    IFU uncached read requester
//   icu_req/addr/single/ack           ICU refill requester (addr is [31:3])
//   icu_data_valid/last/fault         ICU beat qualifiers
//   rd_data                           shared return data
//   ar_*                              AR channel (master side)
//   r_*                               R channel (master side)
//   id_err                            sticky flag: R beat with unexpected id
//
// State table:
//   S_IDLE | no transaction; arbitrate pending requests
//   S_ADDR | AR valid, fields held until ar_ready
//   S_DATA | R ready, waiting for matching beats up to r_last

module c7b_rd_arb #(
  parameter int         ICU_BURST_LEN = 4,
  parameter logic [3:0] LSU_ID        = 4'd1,
  parameter logic [3:0] IFU_ID        = 4'd2,
  parameter logic [3:0] ICU_ID        = 4'd3
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic        lsu_rd_req,
  input  logic [31:0] lsu_rd_addr,
  output logic        lsu_rd_ack,
  output logic        lsu_data_valid,
  input  logic        ifu_rd_req,
  input  logic [31:0] ifu_rd_addr,
  output logic        ifu_rd_ack,
  output logic        ifu_data_valid,
  input  logic        icu_req,
  input  logic [28:0] icu_addr,
  input  logic        icu_single,
  output logic        icu_ack,
  output logic        icu_data_valid,
  output logic        icu_data_last,
  output logic        icu_fault,
  output logic [63:0] rd_data,
  output logic        ar_valid,
  input  logic        ar_ready,
  output logic [3:0]  ar_id,
  output logic [31:0] ar_addr,
  output logic [7:0]  ar_len,
  input  logic        r_valid,
  output logic        r_ready,
  input  logic [3:0]  r_id,
  input  logic [63:0] r_data,
  input  logic        r_last,
  input  logic [1:0]  r_resp,
  output logic        id_err
);

  typedef enum logic [1:0] {S_IDLE, S_ADDR, S_DATA} state_t;
  typedef enum logic [1:0] {G_LSU = 2'd0, G_ICU = 2'd1, G_IFU = 2'd2} grant_t;

  state_t state;
  grant_t grant;
  grant_t pick;
  logic   any_req;
  logic   ar_hs;
  logic   beat_ok;

  assign any_req = lsu_rd_req | icu_req | ifu_rd_req;
  assign ar_hs   = ar_valid & ar_ready;

`ifdef C7B_RD_ARB_RR_EN
  logic [1:0] last_grant;

  // Highest priority goes to the requester following the last winner.
  always_comb begin
    pick = G_LSU;
    case (last_grant)
      2'd0: begin
        if (icu_req)         pick = G_ICU;
        else if (ifu_rd_req) pick = G_IFU;
        else                 pick = G_LSU;
      end
      2'd1: begin
        if (ifu_rd_req)      pick = G_IFU;
        else if (lsu_rd_req) pick = G_LSU;
        else                 pick = G_ICU;
      end
      default: begin
        if (lsu_rd_req)      pick = G_LSU;
        else if (icu_req)    pick = G_ICU;
        else                 pick = G_IFU;
      end
    endcase
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      last_grant <= 2'd0;
    end else if (ar_hs) begin
      last_grant <= grant;
    end
  end
`else
  always_comb begin
    pick = G_LSU;
    if (lsu_rd_req)   pick = G_LSU;
    else if (icu_req) pick = G_ICU;
    else              pick = G_IFU;
  end
`endif

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state    <= S_IDLE;
      grant    <= G_LSU;
      ar_valid <= 1'b0;
      ar_addr  <= '0;
      ar_id    <= '0;
      ar_len   <= '0;
      id_err   <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          if (any_req) begin
            grant    <= pick;
            ar_valid <= 1'b1;
            state    <= S_ADDR;
            case (pick)
              G_ICU: begin
                ar_addr <= {icu_addr, 3'b000};
                ar_id   <= ICU_ID;
                ar_len  <= icu_single ? 8'd0 : 8'(ICU_BURST_LEN - 1);
              end
              G_IFU: begin
                ar_addr <= ifu_rd_addr;
                ar_id   <= IFU_ID;
                ar_len  <= 8'd0;
              end
              default: begin
                ar_addr <= lsu_rd_addr;
                ar_id   <= LSU_ID;
                ar_len  <= 8'd0;
              end
            endcase
          end
        end
        S_ADDR: begin
          if (ar_ready) begin
            ar_valid <= 1'b0;
            state    <= S_DATA;
          end
        end
        S_DATA: begin
          // Beats with a foreign id are consumed and dropped; only the flag moves.
          if (r_valid) begin
            if (r_id == ar_id) begin
              if (r_last) state <= S_IDLE;
            end else begin
              id_err <= 1'b1;
            end
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  assign lsu_rd_ack = ar_hs & (grant == G_LSU);
  assign icu_ack    = ar_hs & (grant == G_ICU);
  assign ifu_rd_ack = ar_hs & (grant == G_IFU);

  assign r_ready = (state == S_DATA);
  assign beat_ok = r_ready & r_valid & (r_id == ar_id);

  assign lsu_data_valid = beat_ok & (grant == G_LSU);
  assign icu_data_valid = beat_ok & (grant == G_ICU);
  assign ifu_data_valid = beat_ok & (grant == G_IFU);
  assign icu_data_last  = icu_data_valid & r_last;
  assign icu_fault      = icu_data_valid & (r_resp != 2'b00);
  assign rd_data        = beat_ok ? r_data : 64'd0;

endmodule

// File: tb/tb_c7b_rd_arb.sv
module tb_c7b_rd_arb;

  localparam int BURST = 4;

  logic        clk = 1'b0;
  logic        resetn;
  logic        lsu_rd_req, ifu_rd_req, icu_req, icu_single;
  logic [31:0] lsu_rd_addr, ifu_rd_addr;
  logic [28:0] icu_addr;
  logic        lsu_rd_ack, lsu_data_valid, ifu_rd_ack, ifu_data_valid;
  logic        icu_ack, icu_data_valid, icu_data_last, icu_fault;
  logic [63:0] rd_data;
  logic        ar_valid, ar_ready;
  logic [3:0]  ar_id;
  logic [31:0] ar_addr;
  logic [7:0]  ar_len;
  logic        r_valid, r_ready, r_last;
  logic [3:0]  r_id;
  logic [63:0] r_data;
  logic [1:0]  r_resp;
  logic        id_err;

  c7b_rd_arb #(.ICU_BURST_LEN(BURST)) dut (
    .clk(clk), .resetn(resetn),
    .lsu_rd_req(lsu_rd_req), .lsu_rd_addr(lsu_rd_addr), .lsu_rd_ack(lsu_rd_ack),
    .lsu_data_valid(lsu_data_valid),
    .ifu_rd_req(ifu_rd_req), .ifu_rd_addr(ifu_rd_addr), .ifu_rd_ack(ifu_rd_ack),
    .ifu_data_valid(ifu_data_valid),
    .icu_req(icu_req), .icu_addr(icu_addr), .icu_single(icu_single), .icu_ack(icu_ack),
    .icu_data_valid(icu_data_valid), .icu_data_last(icu_data_last), .icu_fault(icu_fault),
    .rd_data(rd_data),
    .ar_valid(ar_valid), .ar_ready(ar_ready), .ar_id(ar_id), .ar_addr(ar_addr), .ar_len(ar_len),
    .r_valid(r_valid), .r_ready(r_ready), .r_id(r_id), .r_data(r_data), .r_last(r_last),
    .r_resp(r_resp), .id_err(id_err)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, obs, exp);
    end
  endtask

  // Requester index: 0 = LSU, 1 = ICU, 2 = IFU (also the rotation order).
  bit   [2:0] pend;
  int         m_phase;   // 0 no transaction, 1 address offered, 2 data return
  int         m_own;
  logic [31:0] m_addr;
  logic [3:0]  m_id;
  logic [7:0]  m_len;
  int         m_left;
  int         m_last;
  logic       m_iderr;
  bit         rst_now, did_dir_rst, match;
  int         pct, n_done;
  int         ids [3] = '{1, 3, 2};
  logic [3:0] bad_ids [4] = '{4'd0, 4'd7, 4'd15, 4'd5};

  function automatic int pick_winner(bit [2:0] p, int last);
`ifdef C7B_RD_ARB_RR_EN
    for (int k = 1; k <= 3; k++) begin
      int c;
      c = (last + k) % 3;
      if (p[c]) return c;
    end
`else
    for (int c = 0; c < 3; c++) if (p[c]) return c;
`endif
    return -1;
  endfunction

  task automatic check_reset_outputs(input string tag);
    check({tag, "_ar_valid"}, ar_valid, 0);
    check({tag, "_ar_addr"}, ar_addr, 0);
    check({tag, "_ar_id"}, ar_id, 0);
    check({tag, "_ar_len"}, ar_len, 0);
    check({tag, "_r_ready"}, r_ready, 0);
    check({tag, "_acks"}, {lsu_rd_ack, icu_ack, ifu_rd_ack}, 0);
    check({tag, "_dv"}, {lsu_data_valid, icu_data_valid, ifu_data_valid}, 0);
    check({tag, "_icu_last_fault"}, {icu_data_last, icu_fault}, 0);
    check({tag, "_rd_data"}, rd_data, 0);
    check({tag, "_id_err"}, id_err, 0);
  endtask

  initial begin
    resetn = 1'b0;
    {lsu_rd_req, ifu_rd_req, icu_req, icu_single, ar_ready, r_valid, r_last} = '0;
    lsu_rd_addr = '0; ifu_rd_addr = '0; icu_addr = '0;
    r_id = '0; r_data = '0; r_resp = '0;
    pend = '0; m_phase = 0; m_last = 0; m_iderr = 1'b0; did_dir_rst = 0; n_done = 0;
    m_own = 0; m_addr = '0; m_id = '0; m_len = '0; m_left = 0;
    repeat (3) @(negedge clk);
    #1 check_reset_outputs("init_rst");

    for (int cyc = 0; cyc < 6000; cyc++) begin
      @(negedge clk);
      // Reset in the middle of an ICU burst (second beat pending), plus rare random ones.
      rst_now = 1'b0;
      if (!did_dir_rst && m_phase == 2 && m_own == 1 && m_len == 8'(BURST - 1) && m_left == BURST - 1) begin
        rst_now = 1'b1;
        did_dir_rst = 1'b1;
      end else if (cyc > 50 && $urandom_range(0, 499) == 0) begin
        rst_now = 1'b1;
      end
      resetn = !rst_now;

      pct = (cyc < 3000) ? 70 : 15;
      for (int i = 0; i < 3; i++) begin
        if (!pend[i] && $urandom_range(0, 99) < pct) begin
          pend[i] = 1'b1;
          if (i == 0) lsu_rd_addr = ($urandom_range(0, 7) == 0) ? 32'h1000_0008 : $urandom;
          if (i == 1) begin
            icu_addr   = ($urandom_range(0, 7) == 0) ? 29'h0000_0400 : 29'($urandom);
            icu_single = 1'($urandom_range(0, 2) == 0);
          end
          if (i == 2) ifu_rd_addr = $urandom;
        end
      end
      lsu_rd_req = pend[0];
      icu_req    = pend[1];
      ifu_rd_req = pend[2];

      ar_ready = ($urandom_range(0, 2) != 0);
      r_data   = {$urandom, $urandom};
      r_resp   = ($urandom_range(0, 3) == 0) ? 2'($urandom_range(1, 3)) : 2'b00;
      if (m_phase == 2) begin
        r_valid = ($urandom_range(0, 4) != 0);
        if ($urandom_range(0, 9) == 0) begin
          r_id   = bad_ids[$urandom_range(0, 3)];
          r_last = 1'($urandom_range(0, 1));
        end else begin
          r_id   = m_id;
          r_last = (m_left == 1);
        end
      end else begin
        // Noise on R while no data is expected; must be ignored entirely.
        r_valid = ($urandom_range(0, 3) == 0);
        r_id    = 4'($urandom);
        r_last  = 1'($urandom_range(0, 1));
      end
      #1;

      if (rst_now) begin
        check_reset_outputs("mid_rst");
        m_phase = 0;
        m_last  = 0;
        m_iderr = 1'b0;
        continue;
      end

      check("id_err", id_err, m_iderr);
      case (m_phase)
        0: begin
          check("idle_ar_valid", ar_valid, 0);
          check("idle_r_ready", r_ready, 0);
          check("idle_acks", {lsu_rd_ack, icu_ack, ifu_rd_ack}, 0);
          check("idle_dv", {lsu_data_valid, icu_data_valid, ifu_data_valid}, 0);
        end
        1: begin
          check("ar_valid", ar_valid, 1);
          check("ar_addr", ar_addr, m_addr);
          check("ar_id", ar_id, m_id);
          check("ar_len", ar_len, m_len);
          check("addr_r_ready", r_ready, 0);
          check("lsu_ack", lsu_rd_ack, (m_own == 0) && ar_ready);
          check("icu_ack", icu_ack, (m_own == 1) && ar_ready);
          check("ifu_ack", ifu_rd_ack, (m_own == 2) && ar_ready);
          check("addr_dv", {lsu_data_valid, icu_data_valid, ifu_data_valid}, 0);
        end
        default: begin
          match = r_valid && (r_id == m_id);
          check("data_ar_valid", ar_valid, 0);
          check("data_acks", {lsu_rd_ack, icu_ack, ifu_rd_ack}, 0);
          check("r_ready", r_ready, 1);
          check("lsu_dv", lsu_data_valid, match && m_own == 0);
          check("icu_dv", icu_data_valid, match && m_own == 1);
          check("ifu_dv", ifu_data_valid, match && m_own == 2);
          check("icu_last", icu_data_last, match && m_own == 1 && r_last);
          check("icu_fault", icu_fault, match && m_own == 1 && r_resp != 2'b00);
          if (match) check("rd_data", rd_data, r_data);
        end
      endcase

      // Advance the reference model across the coming clock edge.
      case (m_phase)
        0: begin
          int w;
          w = pick_winner(pend, m_last);
          if (w >= 0) begin
            m_own = w;
            m_id  = 4'(ids[w]);
            m_len = 8'd0;
            if (w == 0) m_addr = lsu_rd_addr;
            if (w == 2) m_addr = ifu_rd_addr;
            if (w == 1) begin
              m_addr = {icu_addr, 3'b000};
              m_len  = icu_single ? 8'd0 : 8'(BURST - 1);
            end
            m_phase = 1;
          end
        end
        1: begin
          if (ar_ready) begin
            pend[m_own] = 1'b0;
            m_last  = m_own;
            m_left  = int'(m_len) + 1;
            m_phase = 2;
          end
        end
        default: begin
          if (r_valid && r_id != m_id) m_iderr = 1'b1;
          else if (r_valid) begin
            m_left--;
            if (r_last) begin
              m_phase = 0;
              n_done++;
            end
          end
        end
      endcase
    end

    @(negedge clk);
    #1 check("id_err_end", id_err, m_iderr);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/c7b_rd_arb.md
Name: c7b_rd_arb

Overview:
Read-channel arbiter and sequencer between three read requesters (LSU, IFU uncached fetch, ICU line refill) and a single AXI-style AR/R channel pair feeding the BIU's external read port.
- Grants one requester at a time and issues one AR per grant.
- Steers returning R beats back to the owner.
- Allows at most one read transaction outstanding.

Parameters:
- ICU_BURST_LEN, 4: beats per ICU line refill; ar_len = ICU_BURST_LEN-1 when icu_single=0.
- LSU_ID, 4'd1: AR/R id used for LSU reads.
- IFU_ID, 4'd2: AR/R id used for IFU reads.
- ICU_ID, 4'd3: AR/R id used for ICU reads.

Ports:
- clk  in  1  clock
- resetn  in  1  asynchronous active-low reset
- lsu_rd_req  in  1  LSU read request, level, held until ack
- lsu_rd_addr  in  32  LSU byte address
- lsu_rd_ack  out  1  1-cycle pulse, AR for LSU accepted
- lsu_data_valid  out  1  LSU data beat valid
- ifu_rd_req  in  1  IFU uncached read request, level
- ifu_rd_addr  in  32  IFU byte address
- ifu_rd_ack  out  1  1-cycle pulse, AR for IFU accepted
- ifu_data_valid  out  1  IFU data beat valid
- icu_req  in  1  ICU refill request, level
- icu_addr  in  29  ICU address [31:3]
- icu_single  in  1  1 = single beat, 0 = full line burst
- icu_ack  out  1  1-cycle pulse, AR for ICU accepted
- icu_data_valid  out  1  ICU data beat valid
- icu_data_last  out  1  final ICU beat
- icu_fault  out  1  r_resp != 0 on the current ICU beat
- rd_data  out  64  shared return data, qualified by the *_data_valid outputs
- ar_valid  out  1  AR valid
- ar_ready  in  1  AR ready
- ar_id  out  4  AR id
- ar_addr  out  32  AR address
- ar_len  out  8  AR burst length minus 1
- r_valid  in  1  R valid
- r_ready  out  1  R ready
- r_id  in  4  R id
- r_data  in  64  R data
- r_last  in  1  R last
- r_resp  in  2  R response
- id_err  out  1  sticky: R beat seen with an unexpected id

Behaviour:
- Reset (resetn=0, asynchronous): state IDLE; all outputs 0, including id_err; grant cleared. Reset asserted mid-transaction abandons it, with no ack or data delivered afterwards.
- FSM: IDLE -> ADDR -> DATA -> IDLE.
- IDLE:
  - If any request is pending, the arbiter picks a winner (fixed priority LSU > ICU > IFU).
  - Latches grant, ar_addr, ar_id and ar_len; goes to ADDR next cycle.
  - No request: stays in IDLE.
- ADDR:
  - ar_valid=1; ar_addr/ar_id/ar_len held stable until ar_ready.
  - On ar_valid & ar_ready: that cycle the granted *_ack pulses high for one cycle; ar_valid drops next cycle; state moves to DATA.
- Address and length formation:
  - ICU: ar_addr = {icu_addr,3'b000}; ar_len = icu_single ? 0 : ICU_BURST_LEN-1.
  - LSU/IFU: ar_addr = rd_addr unchanged; ar_len = 0.
- DATA:
  - r_ready=1 (combinational from state).
  - Each r_valid with r_id == latched id: rd_data = r_data and the owner's *_data_valid = 1, same cycle (zero-cycle pass-through).
  - For ICU, icu_data_last = r_last and icu_fault = (r_resp != 2'b00).
  - On a matching beat with r_last=1: return to IDLE next cycle.
- Mismatched r_id: beat is accepted and discarded, no data_valid, id_err set (sticky until reset), state unchanged.
- Requests arriving during ADDR or DATA wait; they are evaluated in IDLE only. Minimum gap between consecutive ARs is 1 IDLE cycle.
- Request dropped by a requester before its ack: not supported. The grant is already latched and the transaction completes.
- Simultaneous requests: exactly one winner per IDLE cycle; losers stay pending.

Optional Feature:
- C7B_RD_ARB_RR_EN defined: round-robin arbitration.
  - A 2-bit last-grant register (reset 0 = LSU) rotates priority so the requester after the last winner in order LSU -> ICU -> IFU -> LSU has highest priority.
  - The register updates on the AR handshake.
- Undefined: fixed priority LSU > ICU > IFU; no rotation register is instantiated.

Test Plan:
- LSU read 0x1000_0008, ar_ready same cycle: ar_id=1, ar_len=0, lsu_rd_ack one pulse; one R beat 0xDEAD_BEEF_0000_0001 (r_last=1) -> lsu_data_valid=1 and rd_data matches in that cycle; FSM back to IDLE.
- ICU burst icu_addr=29'h0000_0400, icu_single=0, ar_ready delayed 3 cycles: ar fields stable; ar_addr=0x2000, ar_len=3; 4 beats -> icu_data_valid on 4 cycles, icu_data_last only on beat 4.
- LSU, ICU and IFU requesting in the same cycle, all held: fixed priority grants LSU, ICU, IFU in that order. With C7B_RD_ARB_RR_EN, after an LSU grant and all three held, next order is ICU, then IFU.
- ICU beat with r_resp=2'b10 -> icu_fault=1 on that beat only; transaction still completes on r_last.
- R beat with r_id=4'd7 during an LSU transaction -> no data_valid, id_err=1 and sticky; the later correct beat completes normally.
- resetn pulled low during DATA beat 2 of an ICU burst -> all outputs 0 immediately; after release, a new LSU request is granted normally.
